// File: rtl/snake_step_ctrl.sv
// -----------------------------------------------------------------------------
// snake_step_ctrl
//
// Game-rate controller for a snake game. Turns button presses into a committed
// movement direction, emits a periodic step pulse while the game runs, tracks
// snake length, and sequences IDLE -> RUN -> WIN/LOSE -> IDLE.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   btn      in   4  synchronized button levels (0 up, 1 right, 2 down, 3 left)
//   eat      in   1  pulse, head reached food
//   collide  in   1  pulse, head hit wall or body
//   step     out  1  pulse, advance snake one cell
//   dir      out  2  committed direction (same encoding as btn index)
//   len      out  5  current snake length
//   ovf      out  1  sticky win flag
//   state    out  2  0 IDLE, 1 RUN, 2 WIN, 3 LOSE
//
// Configuration macro
//   SNAKE_RR_ARB_EN  defined   -> round-robin grant among simultaneous rises
//                    undefined -> fixed priority, lowest index wins
// -----------------------------------------------------------------------------
module snake_step_ctrl #(
   parameter int STEP_DIV = 1000,
   parameter int LEN_MAX  = 24,
   parameter int LEN_INIT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn,
   input  logic       eat,
   input  logic       collide,
   output logic       step,
   output logic [1:0] dir,
   output logic [4:0] len,
   output logic       ovf,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WIN  = 2'd2,
      ST_LOSE = 2'd3
   } state_t;

   localparam int             TW         = $clog2(STEP_DIV);
   localparam logic [TW-1:0]  TMAX       = TW'(STEP_DIV - 1);
   localparam logic [4:0]     LEN_INIT_V = 5'(LEN_INIT);
   localparam logic [4:0]     LEN_MAX_V  = 5'(LEN_MAX);

   state_t        r_state, w_state_next;
   logic [TW-1:0] r_timer, w_timer_next;
   logic [1:0]    r_dir, w_dir_next;
   logic [1:0]    r_pend_dir, w_pend_dir_next;
   logic          r_pend_valid, w_pend_valid_next;
   logic [4:0]    r_len, w_len_next;
   logic          r_ovf, w_ovf_next;
   logic [3:0]    r_btn_prev;

   logic [3:0]    w_rise;
   logic          w_grant_valid;
   logic [1:0]    w_grant_idx;
   logic          w_timer_max;
   logic          w_step;
   logic [1:0]    w_ref_dir;

   // Only 0->1 transitions count; a held button never re-triggers.
   assign w_rise = btn & ~r_btn_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) r_btn_prev <= 4'b0000;
      else        r_btn_prev <= btn;
   end

`ifdef SNAKE_RR_ARB_EN
   // Pointer holds the index where the next search begins (last grant + 1).
   logic [1:0] r_arb_ptr;

   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_idx   = 2'd0;
      // Walk from farthest to nearest so the nearest rise to the pointer wins.
      for (int k = 3; k >= 0; k--) begin
         if (w_rise[r_arb_ptr + 2'(k)]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = r_arb_ptr + 2'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)             r_arb_ptr <= 2'd0;
      else if (w_grant_valid) r_arb_ptr <= w_grant_idx + 2'd1;
   end
`else
   always_comb begin
      w_grant_valid = 1'b1;
      w_grant_idx   = 2'd0;
      if      (w_rise[0]) w_grant_idx = 2'd0;
      else if (w_rise[1]) w_grant_idx = 2'd1;
      else if (w_rise[2]) w_grant_idx = 2'd2;
      else if (w_rise[3]) w_grant_idx = 2'd3;
      else                w_grant_valid = 1'b0;
   end
`endif

   assign w_timer_max = (r_timer == TMAX);
   // Gated by rst_n so a reset asserted in a step cycle suppresses the pulse.
   assign w_step      = rst_n && (r_state == ST_RUN) && w_timer_max;
   // In a step cycle the pending turn is about to become the heading, so a
   // simultaneous press is judged against it rather than the old heading.
   assign w_ref_dir   = (w_step && r_pend_valid) ? r_pend_dir : r_dir;

   always_comb begin
      w_state_next      = r_state;
      w_timer_next      = r_timer;
      w_dir_next        = r_dir;
      w_pend_dir_next   = r_pend_dir;
      w_pend_valid_next = r_pend_valid;
      w_len_next        = r_len;
      w_ovf_next        = r_ovf;

      case (r_state)
         ST_IDLE: begin
            if (w_grant_valid) begin
               w_state_next      = ST_RUN;
               w_dir_next        = w_grant_idx;
               w_timer_next      = '0;
               w_pend_valid_next = 1'b0;
            end
         end

         ST_RUN: begin
            w_timer_next = w_timer_max ? '0 : r_timer + 1'b1;

            if (w_timer_max && r_pend_valid) begin
               w_dir_next        = r_pend_dir;
               w_pend_valid_next = 1'b0;
            end

            // A fresh non-reversing press replaces any queued turn.
            if (w_grant_valid && (w_grant_idx != (w_ref_dir ^ 2'b10))) begin
               w_pend_dir_next   = w_grant_idx;
               w_pend_valid_next = 1'b1;
            end

            // Collision dominates a coincident eat.
            if (collide) begin
               w_state_next = ST_LOSE;
            end else if (eat) begin
               w_len_next = r_len + 5'd1;
               if (r_len + 5'd1 == LEN_MAX_V) begin
                  w_ovf_next   = 1'b1;
                  w_state_next = ST_WIN;
               end
            end
         end

         ST_WIN, ST_LOSE: begin
            if (w_grant_valid) begin
               w_state_next      = ST_IDLE;
               w_len_next        = LEN_INIT_V;
               w_ovf_next        = 1'b0;
               w_dir_next        = 2'd0;
               w_pend_valid_next = 1'b0;
               w_timer_next      = '0;
            end
         end

         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_timer      <= '0;
         r_dir        <= 2'd0;
         r_pend_dir   <= 2'd0;
         r_pend_valid <= 1'b0;
         r_len        <= LEN_INIT_V;
         r_ovf        <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_timer      <= w_timer_next;
         r_dir        <= w_dir_next;
         r_pend_dir   <= w_pend_dir_next;
         r_pend_valid <= w_pend_valid_next;
         r_len        <= w_len_next;
         r_ovf        <= w_ovf_next;
      end
   end

   assign step  = w_step;
   assign dir   = r_dir;
   assign len   = r_len;
   assign ovf   = r_ovf;
   assign state = r_state;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_step_ctrl
//
// Directed testbench for snake_step_ctrl with STEP_DIV=8, LEN_MAX=5, LEN_INIT=3.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_snake_step_ctrl;

   localparam int STEP_DIV = 8;
   localparam int LEN_MAX  = 5;
   localparam int LEN_INIT = 3;

   logic       clk;
   logic       rst_n;
   logic [3:0] btn;
   logic       eat;
   logic       collide;
   logic       step;
   logic [1:0] dir;
   logic [4:0] len;
   logic       ovf;
   logic [1:0] state;

   int errors;
   int checks;

   snake_step_ctrl #(
      .STEP_DIV (STEP_DIV),
      .LEN_MAX  (LEN_MAX),
      .LEN_INIT (LEN_INIT)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn     (btn),
      .eat     (eat),
      .collide (collide),
      .step    (step),
      .dir     (dir),
      .len     (len),
      .ovf     (ovf),
      .state   (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Advance until a step pulse is visible; leaves time inside the step cycle.
   task automatic wait_step(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4 * STEP_DIV && !seen; i++) begin
         cyc();
         if (step === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: step pulse not seen within %0d cycles", name, 4 * STEP_DIV);
      end
   endtask

   task automatic press(input logic [3:0] b);
      btn = b;
      cyc();
      btn = 4'b0000;
      cyc();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; btn = 4'b0000; eat = 1'b0; collide = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if (dir !== 2'd0)   begin errors++; $display("FAIL reset_dir: got %0d expected 0", dir); end
      checks++; if (len !== 5'd3)   begin errors++; $display("FAIL reset_len: got %0d expected 3", len); end
      checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf: got %0d expected 0", ovf); end
      checks++; if (step !== 1'b0)  begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
      $display("test_reset: state=%0d dir=%0d len=%0d ovf=%0d", state, dir, len, ovf);
   endtask

   // Enter RUN with right; step must appear on the 8th RUN cycle and every 8.
   task automatic test_step_timing();
      logic exp_step;
      do_reset();
      btn = 4'b0010;
      cyc();
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", state); end
      checks++; if (dir !== 2'd1)   begin errors++; $display("FAIL start_dir: got %0d expected 1", dir); end
      for (int i = 0; i <= 16; i++) begin
         exp_step = (i == 7 || i == 15);
         checks++;
         if (step !== exp_step) begin
            errors++;
            $display("FAIL step_timing[%0d]: got %0b expected %0b", i, step, exp_step);
         end
         if (i == 0) btn = 4'b0000;
         if (i < 16) cyc();
      end
      $display("test_step_timing: state=%0d dir=%0d", state, dir);
   endtask

   // Reversal discard, last-wins pending, and step-cycle reference direction.
   task automatic test_direction();
      do_reset();
      press(4'b0001);                       // RUN, dir=0 (timer now 1)
      press(4'b0100);                       // down is reversal of up
      wait_step("rev_wait"); cyc();
      checks++; if (dir !== 2'd0) begin errors++; $display("FAIL reversal_discard: got %0d expected 0", dir); end
      press(4'b0010);                       // right pending
      press(4'b1000);                       // left overwrites
      checks++; if (dir !== 2'd0) begin errors++; $display("FAIL dir_before_step: got %0d expected 0", dir); end
      wait_step("lastwins_wait"); cyc();
      checks++; if (dir !== 2'd3) begin errors++; $display("FAIL last_wins: got %0d expected 3", dir); end
      // Press up exactly in the step cycle with nothing pending: queued for next step.
      wait_step("samecyc_wait");
      btn = 4'b0001; cyc(); btn = 4'b0000;
      checks++; if (dir !== 2'd3) begin errors++; $display("FAIL samecyc_hold: got %0d expected 3", dir); end
      wait_step("samecyc_wait2"); cyc();
      checks++; if (dir !== 2'd0) begin errors++; $display("FAIL samecyc_commit: got %0d expected 0", dir); end
      // Right pending; left in step cycle reverses the pending turn -> discarded.
      press(4'b0010);
      wait_step("refdir_wait");
      btn = 4'b1000; cyc(); btn = 4'b0000;
      checks++; if (dir !== 2'd1) begin errors++; $display("FAIL refdir_commit: got %0d expected 1", dir); end
      wait_step("refdir_wait2"); cyc();
      checks++; if (dir !== 2'd1) begin errors++; $display("FAIL refdir_discard: got %0d expected 1", dir); end
      $display("test_direction: dir=%0d", dir);
   endtask

   task automatic test_arbiter();
      logic [1:0] exp_dir;
`ifdef SNAKE_RR_ARB_EN
      exp_dir = 2'd3;
`else
      exp_dir = 2'd1;
`endif
      do_reset();
      press(4'b0001);                       // RUN, dir=0
      press(4'b1010);
      press(4'b1010);
      wait_step("arb_wait"); cyc();
      checks++; if (dir !== exp_dir) begin errors++; $display("FAIL arbiter_grant: got %0d expected %0d", dir, exp_dir); end
      $display("test_arbiter: dir=%0d", dir);
   endtask

   task automatic test_eat_win();
      do_reset();
      press(4'b0001);
      eat = 1'b1; cyc(); eat = 1'b0;
      checks++; if (len !== 5'd4)   begin errors++; $display("FAIL eat1_len: got %0d expected 4", len); end
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL eat1_state: got %0d expected 1", state); end
      eat = 1'b1; cyc(); eat = 1'b0;
      checks++; if (len !== 5'd5)   begin errors++; $display("FAIL eat2_len: got %0d expected 5", len); end
      checks++; if (ovf !== 1'b1)   begin errors++; $display("FAIL eat2_ovf: got %0d expected 1", ovf); end
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL eat2_state: got %0d expected 2", state); end
      eat = 1'b1; cyc(); eat = 1'b0;
      checks++; if (len !== 5'd5)   begin errors++; $display("FAIL win_eat_len: got %0d expected 5", len); end
      for (int i = 0; i < 2 * STEP_DIV; i++) begin
         cyc();
         checks++; if (step !== 1'b0) begin errors++; $display("FAIL win_step[%0d]: got %0b expected 0", i, step); end
      end
      btn = 4'b0100; cyc(); btn = 4'b0000;
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL restart_state: got %0d expected 0", state); end
      checks++; if (len !== 5'd3)   begin errors++; $display("FAIL restart_len: got %0d expected 3", len); end
      checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL restart_ovf: got %0d expected 0", ovf); end
      checks++; if (dir !== 2'd0)   begin errors++; $display("FAIL restart_dir: got %0d expected 0", dir); end
      eat = 1'b1; collide = 1'b1; cyc(); eat = 1'b0; collide = 1'b0;
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_ignore_state: got %0d expected 0", state); end
      checks++; if (len !== 5'd3)   begin errors++; $display("FAIL idle_ignore_len: got %0d expected 3", len); end
      $display("test_eat_win: state=%0d len=%0d ovf=%0d", state, len, ovf);
   endtask

   task automatic test_collide();
      do_reset();
      press(4'b0001);
      eat = 1'b1; collide = 1'b1; cyc(); eat = 1'b0; collide = 1'b0;
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL collide_state: got %0d expected 3", state); end
      checks++; if (len !== 5'd3)   begin errors++; $display("FAIL collide_len: got %0d expected 3", len); end
      eat = 1'b1; cyc(); eat = 1'b0;
      checks++; if (len !== 5'd3)   begin errors++; $display("FAIL lose_eat_len: got %0d expected 3", len); end
      for (int i = 0; i < STEP_DIV + 2; i++) begin
         cyc();
         checks++; if (step !== 1'b0) begin errors++; $display("FAIL lose_step[%0d]: got %0b expected 0", i, step); end
      end
      btn = 4'b1000; cyc(); btn = 4'b0000;
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL lose_restart: got %0d expected 0", state); end
      $display("test_collide: state=%0d len=%0d", state, len);
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      press(4'b0001);                       // RUN, dir=0
      press(4'b0010);                       // right pending
      wait_step("midrun_wait");
      rst_n = 1'b0; #1;
      checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_cycle_step: got %0b expected 0", step); end
      cyc();
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL midrun_state: got %0d expected 0", state); end
      checks++; if (dir !== 2'd0)   begin errors++; $display("FAIL midrun_dir: got %0d expected 0", dir); end
      checks++; if (step !== 1'b0)  begin errors++; $display("FAIL midrun_step: got %0b expected 0", step); end
      rst_n = 1'b1; cyc();
      checks++; if (step !== 1'b0)  begin errors++; $display("FAIL after_reset_step: got %0b expected 0", step); end
      press(4'b0001);
      wait_step("midrun_wait2"); cyc();
      checks++; if (dir !== 2'd0)   begin errors++; $display("FAIL pend_cleared: got %0d expected 0", dir); end
      $display("test_reset_mid_run: state=%0d dir=%0d", state, dir);
   endtask

   // A button held across reset release counts as a rise right after release.
   task automatic test_held_through_reset();
      rst_n = 1'b0; btn = 4'b0010; eat = 1'b0; collide = 1'b0;
      cyc(); cyc();
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL held_in_reset: got %0d expected 0", state); end
      rst_n = 1'b1; cyc();
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL held_state: got %0d expected 1", state); end
      checks++; if (dir !== 2'd1)   begin errors++; $display("FAIL held_dir: got %0d expected 1", dir); end
      btn = 4'b0000;
      $display("test_held_through_reset: state=%0d dir=%0d", state, dir);
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0; btn = 4'b0000; eat = 1'b0; collide = 1'b0;
      test_reset();
      test_step_timing();
      test_direction();
      test_arbiter();
      test_eat_win();
      test_collide();
      test_reset_mid_run();
      test_held_through_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/snake_step_ctrl.md
SNAKE_STEP_CTRL -- requirements
Module: snake_step_ctrl

Interface
REQ-001 SHALL have parameter STEP_DIV, default 1000, clock cycles per snake step (legal range 2..65536).
REQ-002 SHALL have parameter LEN_MAX, default 24, snake length that wins the game (legal range LEN_INIT+1..31).
REQ-003 SHALL have parameter LEN_INIT, default 3, snake length after reset or restart.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port btn  input  4  synchronized button levels; index 0 up, 1 right, 2 down, 3 left.
REQ-007 SHALL have port eat  input  1  one-cycle pulse, head reached food.
REQ-008 SHALL have port collide  input  1  one-cycle pulse, head hit wall or body.
REQ-009 SHALL have port step  output  1  one-cycle pulse, advance snake one cell.
REQ-010 SHALL have port dir  output  2  committed direction, encoding as btn index.
REQ-011 SHALL have port len  output  5  current snake length.
REQ-012 SHALL have port ovf  output  1  sticky win flag, len reached LEN_MAX.
REQ-013 SHALL have port state  output  2  FSM state: 0 IDLE, 1 RUN, 2 WIN, 3 LOSE.

Function
REQ-014 SHALL detect button rises as btn & ~btn_prev, btn_prev registered every cycle; held levels never re-trigger.
REQ-015 SHALL grant exactly one rise per cycle among simultaneous rises via the arbiter (REQ-029).
REQ-016 In IDLE, a granted rise SHALL commit dir to the granted index with no reversal check, enter RUN, and clear the step timer to 0.
REQ-017 In RUN, the step timer SHALL count 0..STEP_DIV-1 and wrap to 0; step SHALL be 1 exactly in the cycle the timer equals STEP_DIV-1.
REQ-018 In RUN, a granted rise whose index equals reference direction XOR 2'b10 (reversal) SHALL be discarded; reference direction is pend_dir in a step cycle with pending valid, else dir.
REQ-019 In RUN, a non-reversal granted rise SHALL load pend_dir and set pend_valid, overwriting any earlier pending request (last wins).
REQ-020 In the step cycle, pending valid SHALL commit dir <= pend_dir on the same edge and clear pend_valid; a rise in that same cycle SHALL become the new pending request for the next step.
REQ-021 In RUN, eat SHALL increment len by 1; when the incremented value equals LEN_MAX, SHALL set ovf and enter WIN; len SHALL never exceed LEN_MAX.
REQ-022 In RUN, collide SHALL enter LOSE; collide and eat in the same cycle SHALL give LOSE with len unchanged.
REQ-023 In WIN and LOSE, the timer SHALL stop, step SHALL be 0, and eat/collide SHALL be ignored.
REQ-024 In WIN or LOSE, any button rise SHALL enter IDLE with len=LEN_INIT, ovf=0, dir=0, pend_valid=0, timer=0.
REQ-025 eat/collide SHALL be ignored in IDLE.

Reset
REQ-026 With rst_n=0 at a clock edge: state=IDLE, step=0, dir=0, len=LEN_INIT, ovf=0, timer=0, pend_valid=0, btn_prev=4'b0000, arbiter pointer=0.
REQ-027 Reset mid-RUN SHALL discard any pending request and the partial timer count; no step pulse in the reset cycle or the cycle after.
REQ-028 Buttons held through reset release SHALL register as rises in the first cycle after release.

Configuration
REQ-029 Macro SNAKE_RR_ARB_EN: defined -> round-robin arbiter, search starts at index (last granted+1) mod 4, pointer updates only on a grant; undefined -> fixed priority, lowest index wins, no pointer register.

Verification
REQ-030 Reset, btn=4'b0010 rise -> state=RUN, dir=1 next cycle; step pulses at cycle STEP_DIV-1 and every STEP_DIV cycles thereafter.
REQ-031 RUN dir=0, press down (index 2) -> discarded, dir stays 0; press right then left before the step -> dir=3 after the step.
REQ-032 Simultaneous rise btn=4'b1010 twice with dir=0 -> fixed: grants index 1 both times; with SNAKE_RR_ARB_EN: index 1 then index 3.
REQ-033 LEN_MAX=5, LEN_INIT=3: two eat pulses -> len=5, ovf=1, state=WIN; further eat leaves len=5; a button rise -> IDLE, len=3, ovf=0.
REQ-034 eat and collide same cycle at len=3 -> state=LOSE, len=3; rst_n=0 mid-RUN with pending set -> IDLE, no step, pending cleared.
